// File: rtl/formula_pipe.sv
// formula_pipe: four-stage streaming evaluator of
//   q = floor(((a - b) * (3*c + 1) - 4*d) / 2)
// with valid/ready flow control. Empty stages always load, so a stall only
// holds the stages that are occupied. Every intermediate is sized so that
// overflow cannot occur for any input.
module formula_pipe #(
  parameter int unsigned width = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vld_in,
  output logic                      rdy_in,
  input  logic signed [width-1:0]   a,
  input  logic signed [width-1:0]   b,
  input  logic signed [width-1:0]   c,
  input  logic signed [width-1:0]   d,
  output logic                      vld_out,
  input  logic                      rdy_out,
  output logic signed [2*width+6:0] q
);

  localparam logic signed [width+2:0] OneC = (width+3)'(1);

  // Stage valid bits and load enables
  logic v1_q, v2_q, v3_q, v4_q;
  logic en1, en2, en3, en4;

  // Stage data registers
  logic signed [width:0]     s1_diff_q;
  logic signed [width+2:0]   s1_c3_q;
  logic signed [width+2:0]   s1_d4_q;
  logic signed [2*width+3:0] s2_prod_q;
  logic signed [width+2:0]   s2_d4_q;
  logic signed [2*width+4:0] s3_num_q;
  logic signed [2*width+6:0] s4_q_q;

  // Next-state data for each stage
  logic signed [width:0]     s1_diff_d;
  logic signed [width+2:0]   s1_c3_d;
  logic signed [width+2:0]   s1_d4_d;
  logic signed [width+2:0]   c_ext;
  logic signed [2*width+3:0] s2_prod_d;
  logic signed [2*width+3:0] prod_lhs;
  logic signed [2*width+3:0] prod_rhs;
  logic signed [2*width+4:0] s3_num_d;
  logic signed [2*width+6:0] s4_q_d;

  // A stage may load when it is empty or its successor is loading this cycle
  always_comb begin
    en4    = !v4_q || rdy_out;
    en3    = !v3_q || en4;
    en2    = !v2_q || en3;
    en1    = !v1_q || en2;
    rdy_in = en1;
  end

  // Arithmetic for every stage, all sign-extended to full result width
  always_comb begin
    s1_diff_d = $signed({a[width-1], a}) - $signed({b[width-1], b});
    c_ext     = $signed({{3{c[width-1]}}, c});
    s1_c3_d   = c_ext + (c_ext <<< 1) + OneC;
    s1_d4_d   = $signed({d[width-1], d, 2'b00});

    prod_lhs  = $signed({{(width+3){s1_diff_q[width]}}, s1_diff_q});
    prod_rhs  = $signed({{(width+1){s1_c3_q[width+2]}}, s1_c3_q});
    s2_prod_d = prod_lhs * prod_rhs;

    s3_num_d  = $signed({s2_prod_q[2*width+3], s2_prod_q})
              - $signed({{(width+2){s2_d4_q[width+2]}}, s2_d4_q});

    // Arithmetic shift gives floor division, rounding odd negatives toward -inf
    s4_q_d    = $signed({{2{s3_num_q[2*width+4]}}, s3_num_q}) >>> 1;
  end

  // Valid bits advance on enable; reset flushes all in-flight sets
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      v4_q <= 1'b0;
    end else begin
      if (en1) v1_q <= vld_in;
      if (en2) v2_q <= v1_q;
      if (en3) v3_q <= v2_q;
      if (en4) v4_q <= v3_q;
    end
  end

  // Data loads only when enabled and the upstream stage holds a valid set
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_diff_q <= '0;
      s1_c3_q   <= '0;
      s1_d4_q   <= '0;
      s2_prod_q <= '0;
      s2_d4_q   <= '0;
      s3_num_q  <= '0;
      s4_q_q    <= '0;
    end else begin
      if (en1 && vld_in) begin
        s1_diff_q <= s1_diff_d;
        s1_c3_q   <= s1_c3_d;
        s1_d4_q   <= s1_d4_d;
      end
      if (en2 && v1_q) begin
        s2_prod_q <= s2_prod_d;
        s2_d4_q   <= s1_d4_q;
      end
      if (en3 && v2_q) begin
        s3_num_q <= s3_num_d;
      end
      if (en4 && v3_q) begin
        s4_q_q <= s4_q_d;
      end
    end
  end

  assign vld_out = v4_q;
  assign q       = s4_q_q;

endmodule
